// File: rtl/vga_pkg.sv
// Shared VGA raster constants and coordinate type for the timing generator and renderers.
// Count space is sync -> back porch -> active -> front porch.
package vga_pkg;

  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned H_ACT  = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 33;
  localparam int unsigned V_ACT  = 480;
  localparam int unsigned V_FP   = 10;

  localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned H_ACT_START = H_SYNC + H_BP;
  localparam int unsigned V_ACT_START = V_SYNC + V_BP;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Depth x Width shift register advancing on en_i, with a per-bit reset value.
// Depth = 0 degenerates to a combinational pass-through.
module vga_sync_delay #(
  parameter int unsigned      Depth  = 1,
  parameter int unsigned      Width  = 1,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, en_i};
    assign q_o         = d_i;
  end else begin : g_shift
    logic [Width-1:0] stage_q [Depth];
    logic [Width-1:0] stage_d [Depth];

    always_comb begin
      stage_d = stage_q;
      if (en_i) begin
        stage_d[0] = d_i;
        for (int unsigned i = 1; i < Depth; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          stage_q[i] <= RstVal;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-clock divider, x/y counters, delayed sync/blank, frame pulse.
// Counters are undelayed; sync/blank are aligned to the downstream colour register stage.
module vga_timing_gen #(
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned H_ACT    = vga_pkg::H_ACT,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned V_ACT    = vga_pkg::V_ACT,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned SYNC_DLY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            vga_clk,
  output logic            pix_tick,
  output vga_pkg::coord_t counter_x,
  output vga_pkg::coord_t counter_y,
  output logic            hsync,
  output logic            vsync,
  output logic            blank_n,
  output logic            sync_n,
  output logic            frame_start
);

  localparam int unsigned HTotal    = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned VTotal    = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned HActStart = H_SYNC + H_BP;
  localparam int unsigned VActStart = V_SYNC + V_BP;
  localparam int unsigned HActEnd   = HActStart + H_ACT;
  localparam int unsigned VActEnd   = VActStart + V_ACT;
  localparam int unsigned DivW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2);

  if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be even and >= 2");
  end
  if ((HTotal > 1024) || (VTotal > 1024)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end

  logic [DivW-1:0] div_q, div_d;
  logic            vga_clk_q, vga_clk_d;
  logic            frame_q, frame_d;
  vga_pkg::coord_t x_q, x_d, y_q, y_d;
  logic            x_last, y_last;
  logic            hs_raw, vs_raw, act;
  logic [2:0]      tim_raw, tim_dly;

  always_comb begin
    x_last    = (x_q == vga_pkg::coord_t'(HTotal - 1));
    y_last    = (y_q == vga_pkg::coord_t'(VTotal - 1));
    pix_tick  = (div_q == DivLast);
    div_d     = pix_tick ? '0 : div_q + 1'b1;
    // Registered so vga_clk is glitch-free; high for the upper half of the divider count.
    vga_clk_d = (div_d >= DivHalf);
    x_d       = x_q;
    y_d       = y_q;
    if (pix_tick) begin
      x_d = x_last ? '0 : x_q + 1'b1;
      if (x_last) begin
        y_d = y_last ? '0 : y_q + 1'b1;
      end
    end
    frame_d = pix_tick && x_last && y_last;
  end

  // 11-bit compares so an active window ending exactly at 1024 still decodes correctly.
  always_comb begin
    hs_raw = ({1'b0, x_q} >= 11'(H_SYNC));
    vs_raw = ({1'b0, y_q} >= 11'(V_SYNC));
    act    = ({1'b0, x_q} >= 11'(HActStart)) && ({1'b0, x_q} < 11'(HActEnd)) &&
             ({1'b0, y_q} >= 11'(VActStart)) && ({1'b0, y_q} < 11'(VActEnd));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      vga_clk_q <= 1'b0;
      frame_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      div_q     <= div_d;
      vga_clk_q <= vga_clk_d;
      frame_q   <= frame_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign tim_raw = {hs_raw, vs_raw, act};

  vga_sync_delay #(
    .Depth  (SYNC_DLY),
    .Width  (3),
    .RstVal (3'b110)
  ) u_sync_delay (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (pix_tick),
    .d_i    (tim_raw),
    .q_o    (tim_dly)
  );

  assign {hsync, vsync, blank_n} = tim_dly;
  assign vga_clk     = vga_clk_q;
  assign counter_x   = x_q;
  assign counter_y   = y_q;
  assign sync_n      = 1'b0;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations driven by a shared clock and reset, compared
// every cycle against an arithmetic tick-index model, with random run lengths and async resets.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct {
    int unsigned hs, hb, ha, hf, vs, vb, va, vf, div, dly;
  } tim_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vclk;
    logic       tick;
    logic       hsync;
    logic       vsync;
    logic       blank_n;
    logic       fs;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       vclk_w, tick_w, hs_w, vs_w, bn_w, sn_w, fs_w;
  logic [2:0][9:0]  cx, cy;

  tim_t        cfg [3];
  int unsigned n_edge;
  int unsigned n_tests;
  int unsigned n_fail;
  bit          chk_en;
  bit          fs_valid [3];
  int unsigned fs_last  [3];

  vga_timing_gen u_dflt (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_clk     (vclk_w[0]),
    .pix_tick    (tick_w[0]),
    .counter_x   (cx[0]),
    .counter_y   (cy[0]),
    .hsync       (hs_w[0]),
    .vsync       (vs_w[0]),
    .blank_n     (bn_w[0]),
    .sync_n      (sn_w[0]),
    .frame_start (fs_w[0])
  );

  vga_timing_gen #(
    .H_SYNC (4), .H_BP (3), .H_ACT (8), .H_FP (2),
    .V_SYNC (2), .V_BP (2), .V_ACT (4), .V_FP (1),
    .CLK_DIV (2), .SYNC_DLY (1)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_clk     (vclk_w[1]),
    .pix_tick    (tick_w[1]),
    .counter_x   (cx[1]),
    .counter_y   (cy[1]),
    .hsync       (hs_w[1]),
    .vsync       (vs_w[1]),
    .blank_n     (bn_w[1]),
    .sync_n      (sn_w[1]),
    .frame_start (fs_w[1])
  );

  vga_timing_gen #(
    .H_SYNC (4), .H_BP (3), .H_ACT (8), .H_FP (2),
    .V_SYNC (2), .V_BP (2), .V_ACT (4), .V_FP (1),
    .CLK_DIV (4), .SYNC_DLY (0)
  ) u_fast (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_clk     (vclk_w[2]),
    .pix_tick    (tick_w[2]),
    .counter_x   (cx[2]),
    .counter_y   (cy[2]),
    .hsync       (hs_w[2]),
    .vsync       (vs_w[2]),
    .blank_n     (bn_w[2]),
    .sync_n      (sn_w[2]),
    .frame_start (fs_w[2])
  );

  // Clock edges seen since reset release; the whole model derives from this one number.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edge <= 0;
    else        n_edge <= n_edge + 1;
  end

  function automatic int unsigned h_tot(input tim_t c);
    return c.hs + c.hb + c.ha + c.hf;
  endfunction

  function automatic int unsigned v_tot(input tim_t c);
    return c.vs + c.vb + c.va + c.vf;
  endfunction

  // {hsync, vsync, active} as seen at tick index k after release.
  function automatic logic [2:0] raw_at(input tim_t c, input int unsigned k);
    int unsigned x, y;
    x = k % h_tot(c);
    y = (k / h_tot(c)) % v_tot(c);
    return {x >= c.hs, y >= c.vs,
            (x >= c.hs + c.hb) && (x < c.hs + c.hb + c.ha) &&
            (y >= c.vs + c.vb) && (y < c.vs + c.vb + c.va)};
  endfunction

  function automatic obs_t model(input tim_t c, input int unsigned n);
    obs_t        e;
    int unsigned ph, t;
    ph     = n % c.div;
    t      = n / c.div;
    e.tick = (ph == c.div - 1);
    e.vclk = (ph >= c.div / 2);
    e.x    = 10'(t % h_tot(c));
    e.y    = 10'((t / h_tot(c)) % v_tot(c));
    e.fs   = (n != 0) && (ph == 0) && (t % (h_tot(c) * v_tot(c)) == 0);
    if (t < c.dly) {e.hsync, e.vsync, e.blank_n} = 3'b110;
    else           {e.hsync, e.vsync, e.blank_n} = raw_at(c, t - c.dly);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t n=%0d", tag, got, exp, $time, n_edge);
    end
  endtask

  task automatic check_all();
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      e = model(cfg[i], n_edge);
      check($sformatf("u%0d.counter_x", i), 32'(cx[i]),     32'(e.x));
      check($sformatf("u%0d.counter_y", i), 32'(cy[i]),     32'(e.y));
      check($sformatf("u%0d.vga_clk", i),   32'(vclk_w[i]), 32'(e.vclk));
      check($sformatf("u%0d.pix_tick", i),  32'(tick_w[i]), 32'(e.tick));
      check($sformatf("u%0d.hsync", i),     32'(hs_w[i]),   32'(e.hsync));
      check($sformatf("u%0d.vsync", i),     32'(vs_w[i]),   32'(e.vsync));
      check($sformatf("u%0d.blank_n", i),   32'(bn_w[i]),   32'(e.blank_n));
      check($sformatf("u%0d.sync_n", i),    32'(sn_w[i]),   32'd0);
      check($sformatf("u%0d.frame_start", i), 32'(fs_w[i]), 32'(e.fs));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_all();
      for (int i = 1; i < 3; i++) begin
        if (fs_w[i]) begin
          if (fs_valid[i]) begin
            check($sformatf("u%0d.frame_gap", i), n_edge / cfg[i].div - fs_last[i],
                  h_tot(cfg[i]) * v_tot(cfg[i]));
          end
          fs_last[i]  = n_edge / cfg[i].div;
          fs_valid[i] = 1'b1;
        end
      end
    end
  end

  initial begin
    cfg[0] = '{hs: 96, hb: 48, ha: 640, hf: 16, vs: 2, vb: 33, va: 480, vf: 10, div: 2, dly: 1};
    cfg[1] = '{hs: 4, hb: 3, ha: 8, hf: 2, vs: 2, vb: 2, va: 4, vf: 1, div: 2, dly: 1};
    cfg[2] = '{hs: 4, hb: 3, ha: 8, hf: 2, vs: 2, vb: 2, va: 4, vf: 1, div: 4, dly: 0};
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fs_valid[i] = 1'b0;
      fs_last[i]  = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int seg = 0; seg < 6; seg++) begin
      repeat ($urandom_range(1700, 4000)) @(posedge clk);
      // Assert reset between edges: outputs must clear with no clock edge.
      #($urandom_range(1, 4));
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) fs_valid[i] = 1'b0;
      #1;
      check_all();
      repeat ($urandom_range(1, 3)) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end

    repeat (2000) @(posedge clk);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
